// File: rtl/stepper_move_ctrl_if.sv
// Move-command handshake bundle between a command source and stepper_move_ctrl.
interface stepper_move_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 24
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;
  logic [PER_W-1:0] cmd_start_period;
  logic [PER_W-1:0] cmd_ramp;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_start_period, cmd_ramp,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_start_period, cmd_ramp,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Stepper move sequencer: accepts a move command and emits step pulses on a
// symmetric linear accel/cruise/decel period profile, tracking signed position.
module stepper_move_ctrl #(
  parameter int CNT_W = 16,
  parameter int PER_W = 24,
  parameter int POS_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stepper_move_ctrl_if.slave      cmd,
  input  logic                    abort,
  output logic                    step,
  output logic                    motor_en,
  output logic                    motor_dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position,
  output logic [CNT_W-1:0]        steps_left
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [PER_W-1:0]        PER_MIN = PER_W'(2);
  localparam logic [PER_W-1:0]        PER_ONE = PER_W'(1);

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    done_q, done_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]        steps_left_q, steps_left_d;
  logic [CNT_W-1:0]        accel_cnt_q, accel_cnt_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic [PER_W-1:0]        start_q, start_d;
  logic [PER_W-1:0]        ramp_q, ramp_d;
  logic [PER_W-1:0]        cur_q, cur_d;
  logic [PER_W-1:0]        cnt_q, cnt_d;

  logic                    accept;
  logic                    step_now;
  logic [CNT_W-1:0]        left_dec;
  logic [PER_W-1:0]        per_clamp, start_clamp;
  logic [PER_W-1:0]        faster, slower;

  function automatic logic [PER_W-1:0] clamp_min2(input logic [PER_W-1:0] v);
    return (v < PER_MIN) ? PER_MIN : v;
  endfunction

  // cur - ramp with one extra bit so a borrow saturates at the cruise floor.
  function automatic logic [PER_W-1:0] sat_faster(input logic [PER_W-1:0] cur,
                                                  input logic [PER_W-1:0] ramp,
                                                  input logic [PER_W-1:0] floor);
    logic [PER_W:0] diff;
    diff = {1'b0, cur} - {1'b0, ramp};
    if (diff[PER_W] || (diff[PER_W-1:0] < floor)) return floor;
    return diff[PER_W-1:0];
  endfunction

  function automatic logic [PER_W-1:0] sat_slower(input logic [PER_W-1:0] cur,
                                                  input logic [PER_W-1:0] ramp,
                                                  input logic [PER_W-1:0] ceil);
    logic [PER_W:0] sum;
    sum = {1'b0, cur} + {1'b0, ramp};
    if (sum > {1'b0, ceil}) return ceil;
    return sum[PER_W-1:0];
  endfunction

  always_comb begin
    accept      = cmd.cmd_valid && (state_q == IDLE);
    step_now    = (state_q != IDLE) && (cnt_q == PER_ONE) && !abort;
    left_dec    = steps_left_q - CNT_W'(1);
    faster      = sat_faster(cur_q, ramp_q, period_q);
    slower      = sat_slower(cur_q, ramp_q, start_q);
    per_clamp   = clamp_min2(cmd.cmd_period);
    start_clamp = clamp_min2(cmd.cmd_start_period);
    if (start_clamp < per_clamp) start_clamp = per_clamp;

    state_d      = state_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    pos_d        = pos_q;
    steps_left_d = steps_left_q;
    accel_cnt_d  = accel_cnt_q;
    period_d     = period_q;
    start_d      = start_q;
    ramp_d       = ramp_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;

    if (state_q == IDLE) begin
      if (accept) begin
        dir_d        = cmd.cmd_dir;
        period_d     = per_clamp;
        start_d      = start_clamp;
        ramp_d       = cmd.cmd_ramp;
        cur_d        = start_clamp;
        cnt_d        = start_clamp;
        accel_cnt_d  = '0;
        steps_left_d = cmd.cmd_steps;
        if (cmd.cmd_steps == '0) done_d = 1'b1;
        else                     state_d = ACCEL;
      end
    end else if (abort) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (step_now) begin
      steps_left_d = left_dec;
      pos_d        = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
      if (left_dec == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        // Decel check wins so the braking run mirrors the accel run length.
        if ((state_q == DECEL) || (left_dec <= accel_cnt_q)) begin
          state_d = DECEL;
          cur_d   = slower;
        end else if (state_q == ACCEL) begin
          cur_d = faster;
          if (faster != cur_q)    accel_cnt_d = accel_cnt_q + CNT_W'(1);
          if (faster == period_q) state_d = CRUISE;
        end
        cnt_d = cur_d;
      end
    end else begin
      cnt_d = cnt_q - PER_ONE;
    end
  end

  // Control and architecturally visible state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      pos_q        <= '0;
      steps_left_q <= '0;
      accel_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      pos_q        <= pos_d;
      steps_left_q <= steps_left_d;
      accel_cnt_q  <= accel_cnt_d;
    end
  end

  // Profile datapath; only meaningful while a move is active
  always_ff @(posedge clk) begin
    period_q <= period_d;
    start_q  <= start_d;
    ramp_q   <= ramp_d;
    cur_q    <= cur_d;
    cnt_q    <= cnt_d;
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign motor_en      = busy;
  assign motor_dir     = dir_q;
  assign done          = done_q;
  assign step          = step_now;
  assign position      = pos_q;
  assign steps_left    = steps_left_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Randomised and directed bench for stepper_move_ctrl against a step-interval model.
module tb_stepper_move_ctrl;
  localparam int CNT_W = 16;
  localparam int PER_W = 24;
  localparam int POS_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic step, motor_en, motor_dir, busy, done;
  logic signed [POS_W-1:0] position;
  logic [CNT_W-1:0] steps_left;

  int errors = 0;
  int checks = 0;
  logic signed [POS_W-1:0] exp_pos = '0;
  int exp_iv[$];

  stepper_move_ctrl_if #(.CNT_W(CNT_W), .PER_W(PER_W)) ifc ();

  stepper_move_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(ifc.slave), .abort(abort),
    .step(step), .motor_en(motor_en), .motor_dir(motor_dir), .busy(busy),
    .done(done), .position(position), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Expected step-to-step intervals derived from the ramp rules.
  function automatic void build_profile(input int steps, input int per, input int start, input int ramp);
    longint p, s, cur, nc;
    int peak, left;
    bit cruising, slowing;
    exp_iv.delete();
    p = (per < 2) ? 2 : per;
    s = (start < 2) ? 2 : start;
    if (s < p) s = p;
    cur = s; peak = 0; left = steps; cruising = 0; slowing = 0;
    while (left > 0) begin
      exp_iv.push_back(int'(cur));
      left--;
      if (left == 0) break;
      if (slowing || left <= peak) begin
        slowing = 1;
        cur = (cur + ramp > s) ? s : cur + ramp;
      end else if (!cruising) begin
        nc = (cur - ramp < p) ? p : cur - ramp;
        if (nc != cur) peak++;
        cur = nc;
        if (cur == p) cruising = 1;
      end
    end
  endfunction

  task automatic drive_cmd(input bit dir, input int steps, input int per, input int start, input int ramp);
    ifc.cmd_valid        = 1'b1;
    ifc.cmd_dir          = dir;
    ifc.cmd_steps        = CNT_W'(steps);
    ifc.cmd_period       = PER_W'(per);
    ifc.cmd_start_period = PER_W'(start);
    ifc.cmd_ramp         = PER_W'(ramp);
  endtask

  // Issues one command and checks it against exp_iv; poke holds a second command while busy.
  task automatic run_move(input string name, input bit dir, input int steps, input int per,
                          input int start, input int ramp, input bit poke);
    int stc[$];
    int k, done_k, budget, prev, exp_done;
    bit ready_seen;
    budget = 20;
    foreach (exp_iv[i]) budget += exp_iv[i];
    @(negedge clk);
    drive_cmd(dir, steps, per, start, ramp);
    @(posedge clk); #1;
    if (poke) drive_cmd(!dir, 1, 2, 2, 0);
    else ifc.cmd_valid = 1'b0;
    checks++;
    if (busy !== (steps != 0) || motor_en !== (steps != 0) || motor_dir !== dir ||
        ifc.cmd_ready !== (steps == 0)) begin
      errors++;
      $display("FAIL %s start: busy=%b en=%b dir=%b ready=%b expected busy=%b dir=%b",
               name, busy, motor_en, motor_dir, ifc.cmd_ready, steps != 0, dir);
    end
    k = 0; done_k = -1; ready_seen = 0;
    while (k < budget && done_k < 0) begin
      @(negedge clk);
      k++;
      if (step) stc.push_back(k);
      if (done) done_k = k;
      if (ifc.cmd_valid && ifc.cmd_ready) ready_seen = 1;
      if (k == 5) ifc.cmd_valid = 1'b0;
    end
    ifc.cmd_valid = 1'b0;
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end
    if (poke) begin
      checks++;
      if (ready_seen) begin
        errors++;
        $display("FAIL %s busy_ignore: cmd_ready=1 while busy, required 0", name);
      end
    end
    checks++;
    if (stc.size() != exp_iv.size()) begin
      errors++;
      $display("FAIL %s step_count: got %0d required %0d", name, stc.size(), exp_iv.size());
    end
    prev = 0;
    for (int i = 0; i < stc.size() && i < exp_iv.size(); i++) begin
      checks++;
      if (stc[i] - prev != exp_iv[i]) begin
        errors++;
        $display("FAIL %s interval[%0d]: got %0d required %0d", name, i, stc[i] - prev, exp_iv[i]);
      end
      prev = stc[i];
    end
    exp_done = (stc.size() > 0) ? stc[stc.size()-1] + 1 : 1;
    checks++;
    if (done_k != exp_done) begin
      errors++;
      $display("FAIL %s done_time: got %0d required %0d", name, done_k, exp_done);
    end
    exp_pos = dir ? exp_pos + POS_W'(steps) : exp_pos - POS_W'(steps);
    checks++;
    if (position !== exp_pos || steps_left !== '0 || busy !== 1'b0 || motor_en !== 1'b0) begin
      errors++;
      $display("FAIL %s end: pos=%0d left=%0d busy=%b en=%b required pos=%0d left=0 busy=0",
               name, position, steps_left, busy, motor_en, exp_pos);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (step !== 0 || motor_en !== 0 || motor_dir !== 0 || busy !== 0 || done !== 0 ||
        position !== '0 || steps_left !== '0 || ifc.cmd_ready !== 1) begin
      errors++;
      $display("FAIL reset: step=%b en=%b dir=%b busy=%b done=%b pos=%0d left=%0d ready=%b",
               step, motor_en, motor_dir, busy, done, position, steps_left, ifc.cmd_ready);
    end
  endtask

  task automatic test_abort_restart;
    int nsteps, k;
    @(negedge clk);
    drive_cmd(1'b0, 100, 3, 3, 0);
    @(posedge clk); #1 ifc.cmd_valid = 1'b0;
    nsteps = 0; k = 0;
    while (nsteps < 2 && k < 50) begin
      @(negedge clk); k++;
      if (step) nsteps++;
    end
    checks++;
    if (nsteps != 2) begin
      errors++;
      $display("FAIL abort wait: saw %0d steps required 2", nsteps);
    end
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL abort_gate: step=%b required 0", step);
    end
    @(posedge clk); #1 abort = 1'b0;
    exp_pos = exp_pos - 2;
    checks++;
    if (done !== 1 || busy !== 0 || steps_left !== CNT_W'(98) || position !== exp_pos || step !== 0) begin
      errors++;
      $display("FAIL abort_end: done=%b busy=%b left=%0d pos=%0d step=%b required done=1 busy=0 left=98 pos=%0d",
               done, busy, steps_left, position, step, exp_pos);
    end
    exp_iv = '{2, 2};
    run_move("restart", 1'b1, 2, 2, 2, 0, 1'b0);
  endtask

  task automatic test_abort_idle;
    @(negedge clk);
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 0 || busy !== 0 || step !== 0) begin
        errors++;
        $display("FAIL abort_idle: done=%b busy=%b step=%b required 0", done, busy, step);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_random;
    int steps, per, start, ramp;
    bit dir;
    for (int n = 0; n < 25; n++) begin
      dir   = 1'($urandom_range(0, 1));
      steps = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
      per   = $urandom_range(0, 6);
      start = $urandom_range(0, 24);
      ramp  = $urandom_range(0, 6);
      build_profile(steps, per, start, ramp);
      run_move("random", dir, steps, per, start, ramp, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset;
    int k;
    bit seen;
    @(negedge clk);
    drive_cmd(1'b1, 50, 4, 4, 0);
    @(posedge clk); #1 ifc.cmd_valid = 1'b0;
    k = 0;
    while (!step && k < 20) begin
      @(negedge clk); k++;
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (step !== 0 || motor_en !== 0 || motor_dir !== 0 || busy !== 0 || done !== 0 ||
        position !== '0 || steps_left !== '0 || ifc.cmd_ready !== 1) begin
      errors++;
      $display("FAIL async_reset: step=%b en=%b dir=%b busy=%b done=%b pos=%0d left=%0d ready=%b",
               step, motor_en, motor_dir, busy, done, position, steps_left, ifc.cmd_ready);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (step) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL async_reset_quiet: step pulse seen during reset, required none");
    end
    rst_n = 1'b1;
    exp_pos = '0;
    exp_iv = '{3, 3, 3};
    run_move("after_reset", 1'b0, 3, 3, 3, 0, 1'b0);
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    drive_cmd(1'b0, 0, 0, 0, 0);
    ifc.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_abort_restart();
    exp_iv = '{4, 4, 4, 4, 4};
    run_move("cruise", 1'b1, 5, 4, 4, 0, 1'b0);
    exp_iv = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    run_move("ramp_profile", 1'b1, 10, 4, 10, 2, 1'b0);
    exp_iv = '{20, 15, 20};
    run_move("short_move", 1'b0, 3, 2, 20, 5, 1'b0);
    exp_iv.delete();
    run_move("zero_steps", 1'b1, 0, 4, 4, 0, 1'b0);
    exp_iv = '{3, 3, 3, 3, 3, 3};
    run_move("busy_ignore", 1'b1, 6, 3, 3, 0, 1'b1);
    test_abort_idle();
    exp_iv = '{20, 3, 3, 3, 3, 20};
    run_move("saturation", 1'b1, 6, 3, 20, 24'hFFFFFF, 1'b0);
    exp_iv = '{2, 2, 2};
    run_move("clamp", 1'b0, 3, 0, 1, 0, 1'b0);
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Motion-command sequencer upstream of the stepper phase driver. Accepts a move command (direction, step count, speed profile) over a valid/ready handshake. Emits one-cycle step pulses with a symmetric linear acceleration/deceleration ramp, together with the motor enable and direction the phase driver consumes. Tracks absolute signed position and reports completion.

## Interface
- CNT_W, 16, width of step count and remaining-step counter
- PER_W, 24, width of step-period values (units: clk cycles)
- POS_W, 32, width of signed absolute position
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_dir  in  1  1 = positive direction (position increments), 0 = negative
- cmd_steps  in  CNT_W  number of steps to issue
- cmd_period  in  PER_W  cruise (minimum) period between steps
- cmd_start_period  in  PER_W  start/stop (maximum) period
- cmd_ramp  in  PER_W  period change applied after each ramp step
- abort  in  1  stop immediately, no further steps
- step  out  1  one-cycle pulse per motor step; phase driver advances one phase per pulse
- motor_en  out  1  driver enable, equals busy
- motor_dir  out  1  latched cmd_dir, stable for the whole move
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of move (normal or aborted)
- position  out  POS_W  signed absolute step position
- steps_left  out  CNT_W  steps remaining in the current move

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Accept when cmd_valid && cmd_ready. Latch dir, steps, period, start, ramp.
- Clamp any latched period below 2 to 2. If start < period, start := period.
- cmd_steps = 0: no move. done pulses the next cycle, and busy stays 0.
- Otherwise go to ACCEL:
  - cur_period := start, accel_cnt := 0, steps_left := cmd_steps.
  - Load the period counter so the first step occurs cur_period cycles after acceptance.
- On each step:
  - steps_left decrements.
  - position changes by +1 if dir=1, -1 if dir=0 (two's-complement wrap).
  - The period counter reloads with the period chosen for the next interval.
- ACCEL, per step:
  - cur_period := max(cur_period − ramp, period); accel_cnt increments.
  - Go to CRUISE when cur_period reaches period.
  - Go to DECEL when steps_left (after decrement) ≤ accel_cnt. This check has priority.
- CRUISE: cur_period unchanged. Go to DECEL when steps_left ≤ accel_cnt.
- DECEL, per step: cur_period := min(cur_period + ramp, start).
- Ramp arithmetic saturates and is computed at PER_W+1 bits; there is no wrap.
- The move ends when steps_left reaches 0 on a step:
  - Go to IDLE; done pulses the cycle after the last step.
  - busy, motor_en and the inputs to cmd_ready change on that same cycle.
- ramp = 0: the move runs entirely at start period, and accel_cnt stays 0.
- abort while busy:
  - No step is issued in the abort cycle or later.
  - Next cycle: IDLE, done = 1, busy = 0.
  - steps_left holds its value at abort.
- abort while IDLE is ignored.
- cmd_valid while busy is ignored; there is no queueing.

## Timing
- Reset values:
  - IDLE, cmd_ready = 1.
  - step, motor_en, motor_dir, busy and done = 0.
  - position = 0, steps_left = 0.
- Acceptance at cycle T:
  - busy, motor_en and motor_dir are valid at T+1; cmd_ready = 0 at T+1.
  - First step pulse at T+start.
  - Each later step follows the previous one by the then-current period.
- position and steps_left update in the cycle after the step pulse, together with the registered outputs.
- done follows the last step by exactly 1 cycle. A new command may be accepted the cycle after done.
- rst_n asserted mid-move: every output returns to its reset value immediately, and the move is discarded.

## Test plan
- Cruise only:
  - Stimulus: steps=5, period=4, start=4, ramp=0, dir=1.
  - Required: 5 step pulses spaced 4 cycles, first at T+4; position = 5; done one cycle after the 5th step.
- Ramp profile:
  - Stimulus: steps=10, period=4, start=10, ramp=2.
  - Required step intervals: 10, 8, 6, 4, 4, 4, 4, 6, 8, 10.
- Short move (ramp never reaches cruise):
  - Stimulus: steps=3, period=2, start=20, ramp=5.
  - Required step intervals: 20, 15, 20.
- Abort and restart:
  - Stimulus: abort after the 2nd step of a 100-step move, dir=0.
  - Required: no further steps; done next cycle; position = −2; steps_left = 98; new command accepted immediately after.
- Zero steps and busy:
  - Stimulus: steps=0; later, a second cmd_valid while busy.
  - Required: steps=0 gives done with no step and no busy; the command sent while busy is ignored and cmd_ready stays 0.
- Async reset mid-move: all outputs return to reset values immediately, with no further step pulses.
